// File: rtl/usb4_ll_pkg.sv
// Shared types and constants for the USB4 link-layer receive path.
// Holds the deskew FSM state type and the default alignment marker.
package usb4_ll_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEARCH  = 2'd1,
    ALIGNED = 2'd2,
    ERROR   = 2'd3
  } deskew_state_t;

  localparam logic [7:0] DESKEW_MARKER_DEF = 8'hF0;

endpackage

// File: rtl/deskew_lane_fifo.sv
// Single-lane skew FIFO: show-ahead read data, flush has priority over
// read/write, and a write into a full FIFO is only accepted alongside a read.
module deskew_lane_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       rd_en,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_wr;
  logic              do_rd;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap modulo DEPTH on their own.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr && !flush) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/lane_deskew_buffer.sv
// N-lane receive deskew: per-lane FIFOs lock on MARKER, then pop in lockstep.
// Optional DESKEW_STATS_EN adds the sticky max_skew statistic output.
module lane_deskew_buffer
  import usb4_ll_pkg::*;
#(
  parameter int                NUM_LANES = 2,
  parameter int                DATA_W    = 8,
  parameter int                DEPTH     = 8,
  parameter logic [DATA_W-1:0] MARKER    = DESKEW_MARKER_DEF
) (
  input  logic                          fsm_clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          realign,
  input  logic [NUM_LANES-1:0]          in_valid,
  input  logic [NUM_LANES*DATA_W-1:0]   in_data,
  output logic                          out_valid,
  output logic [NUM_LANES*DATA_W-1:0]   out_data,
  output logic                          aligned,
  output logic                          skew_error,
  output deskew_state_t                 state
`ifdef DESKEW_STATS_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0]    max_skew
`endif
);

  localparam int CNT_W = $clog2(DEPTH+1);

  // Handshake: in_valid[i] qualifies in_data lane i for one cycle, there is
  // no backpressure; out_valid qualifies out_data for exactly one cycle.
  deskew_state_t               state_next;
  logic [NUM_LANES-1:0]        lock_q;
  logic [NUM_LANES-1:0]        lock_next;
  logic [NUM_LANES-1:0]        marker_hit;
  logic [NUM_LANES-1:0]        wr_en;
  logic                        flush;
  logic                        rd_avail;
  logic                        rd;
  logic                        any_full_wr;
  logic                        overflow;
  logic [NUM_LANES*DATA_W-1:0] rd_word;
  logic [DATA_W-1:0]           lane_rd    [NUM_LANES];
  logic                        lane_full  [NUM_LANES];
  logic                        lane_empty [NUM_LANES];
  logic [CNT_W-1:0]            lane_count [NUM_LANES];

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    deskew_lane_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk     (fsm_clk),
      .rst     (rst),
      .flush   (flush),
      .wr_en   (wr_en[g]),
      .wr_data (in_data[g*DATA_W +: DATA_W]),
      .rd_en   (rd),
      .rd_data (lane_rd[g]),
      .full    (lane_full[g]),
      .empty   (lane_empty[g]),
      .count   (lane_count[g])
    );
  end

  // Overflow is judged against the unflushed read so that a realign in the
  // same cycle does not mask or fabricate a skew error.
  always_comb begin
    flush       = !enable || (realign && state != IDLE) || state == ERROR;
    rd_avail    = (state == ALIGNED);
    any_full_wr = 1'b0;
    marker_hit  = '0;
    wr_en       = '0;
    rd_word     = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      marker_hit[i] = in_valid[i] && (in_data[i*DATA_W +: DATA_W] == MARKER);
      wr_en[i]      = in_valid[i] &&
                      (state == ALIGNED || (state == SEARCH && lock_q[i]));
      if (lane_empty[i]) rd_avail = 1'b0;
      if (wr_en[i] && lane_full[i]) any_full_wr = 1'b1;
      rd_word[i*DATA_W +: DATA_W] = lane_rd[i];
    end
    rd       = rd_avail && !flush;
    overflow = any_full_wr && !rd_avail;
  end

  always_comb begin
    state_next = state;
    lock_next  = lock_q;
    if (!enable) begin
      state_next = IDLE;
      lock_next  = '0;
    end else if (realign && state != IDLE) begin
      state_next = SEARCH;
      lock_next  = '0;
    end else begin
      case (state)
        IDLE:    state_next = SEARCH;
        SEARCH: begin
          lock_next = lock_q | marker_hit;
          if (overflow)     state_next = ERROR;
          else if (&lock_q) state_next = ALIGNED;
        end
        ALIGNED: if (overflow) state_next = ERROR;
        ERROR: begin
          state_next = SEARCH;
          lock_next  = '0;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge fsm_clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      lock_q <= '0;
    end else begin
      state  <= state_next;
      lock_q <= lock_next;
    end
  end

  always_ff @(posedge fsm_clk or negedge rst) begin
    if (!rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skew_error <= 1'b0;
    end else begin
      out_valid  <= rd;
      skew_error <= overflow;
      if (rd) out_data <= rd_word;
    end
  end

  assign aligned = (state == ALIGNED);

`ifdef DESKEW_STATS_EN
  logic [CNT_W-1:0] cnt_hi;
  logic [CNT_W-1:0] cnt_lo;
  logic [CNT_W-1:0] cur_skew;

  always_comb begin
    cnt_hi = '0;
    cnt_lo = CNT_W'(DEPTH);
    for (int i = 0; i < NUM_LANES; i++) begin
      if (lock_q[i]) begin
        if (lane_count[i] > cnt_hi) cnt_hi = lane_count[i];
        if (lane_count[i] < cnt_lo) cnt_lo = lane_count[i];
      end
    end
    cur_skew = (|lock_q) ? (cnt_hi - cnt_lo) : '0;
  end

  always_ff @(posedge fsm_clk or negedge rst) begin
    if (!rst)                                        max_skew <= '0;
    else if (realign)                                max_skew <= '0;
    else if (state == SEARCH && cur_skew > max_skew) max_skew <= cur_skew;
  end
`else
  // Lane counts only feed the skew statistic.
  logic unused_count;
  always_comb begin
    unused_count = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) unused_count = unused_count ^ (^lane_count[i]);
  end
`endif

endmodule

// File: tb/tb_lane_deskew_buffer.sv
// Bench for lane_deskew_buffer (2 lanes, 8-bit, DEPTH 4): directed scenarios
// plus random traffic against a queue-based model; honours DESKEW_STATS_EN.
module tb_lane_deskew_buffer;
  import usb4_ll_pkg::*;

  localparam int         DEPTH = 4;
  localparam int         CW    = $clog2(DEPTH+1);
  localparam logic [7:0] MARK  = 8'hF0;

  logic          fsm_clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          realign;
  logic [1:0]    in_valid;
  logic [15:0]   in_data;
  logic          out_valid;
  logic [15:0]   out_data;
  logic          aligned;
  logic          skew_error;
  deskew_state_t state;
`ifdef DESKEW_STATS_EN
  logic [CW-1:0] max_skew;
`endif

  int n_vec = 0;
  int n_err = 0;

  // reference model
  deskew_state_t m_state;
  logic [1:0]    m_lock;
  logic [7:0]    exp_q0[$];
  logic [7:0]    exp_q1[$];
  logic          exp_valid;
  logic          exp_err;
  logic [15:0]   exp_data;
  int            m_max;

  // stimulus tables
  logic       sv_v  [2][64];
  logic [7:0] sv_d  [2][64];
  logic       sv_en [64];
  logic       sv_rl [64];
  logic [15:0] got[$];

  always #5 fsm_clk = ~fsm_clk;

  lane_deskew_buffer #(
    .NUM_LANES (2),
    .DATA_W    (8),
    .DEPTH     (DEPTH),
    .MARKER    (MARK)
  ) u_dut (
    .fsm_clk    (fsm_clk),
    .rst        (rst),
    .enable     (enable),
    .realign    (realign),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .aligned    (aligned),
    .skew_error (skew_error),
    .state      (state)
`ifdef DESKEW_STATS_EN
    ,
    .max_skew   (max_skew)
`endif
  );

  task automatic model_reset();
    m_state = IDLE;
    m_lock  = 2'b00;
    exp_q0.delete();
    exp_q1.delete();
    exp_valid = 1'b0;
    exp_err   = 1'b0;
    exp_data  = 16'h0000;
    m_max     = 0;
  endtask

  // One clock of the behavioural model, using the inputs currently driven.
  task automatic model_step();
    logic [7:0]    d [2];
    logic          v [2];
    logic          wr [2];
    logic          hit [2];
    int            sz [2];
    logic          rd, fl, ovf;
    int            hi, lo;
    deskew_state_t ns;
    logic [1:0]    nl;
    v[0] = in_valid[0];
    v[1] = in_valid[1];
    d[0] = in_data[7:0];
    d[1] = in_data[15:8];
    sz[0] = exp_q0.size();
    sz[1] = exp_q1.size();
    rd  = (m_state == ALIGNED) && sz[0] > 0 && sz[1] > 0;
    fl  = !enable || (realign && m_state != IDLE) || (m_state == ERROR);
    ovf = 1'b0;
    for (int l = 0; l < 2; l++) begin
      wr[l]  = v[l] && (m_state == ALIGNED || (m_state == SEARCH && m_lock[l]));
      hit[l] = v[l] && (d[l] == MARK);
      if (wr[l] && sz[l] == DEPTH && !rd) ovf = 1'b1;
    end
    if (realign) m_max = 0;
    else if (m_state == SEARCH) begin
      hi = -1;
      lo = DEPTH + 1;
      for (int l = 0; l < 2; l++) begin
        if (m_lock[l]) begin
          if (sz[l] > hi) hi = sz[l];
          if (sz[l] < lo) lo = sz[l];
        end
      end
      if (hi >= 0 && hi - lo > m_max) m_max = hi - lo;
    end
    ns = m_state;
    nl = m_lock;
    if (!enable) begin
      ns = IDLE;
      nl = 2'b00;
    end else if (realign && m_state != IDLE) begin
      ns = SEARCH;
      nl = 2'b00;
    end else if (m_state == IDLE) begin
      ns = SEARCH;
    end else if (m_state == SEARCH) begin
      nl = m_lock | {hit[1], hit[0]};
      if (ovf) ns = ERROR;
      else if (m_lock == 2'b11) ns = ALIGNED;
    end else if (m_state == ALIGNED) begin
      if (ovf) ns = ERROR;
    end else begin
      ns = SEARCH;
      nl = 2'b00;
    end
    exp_err   = ovf;
    exp_valid = rd && !fl;
    if (exp_valid) exp_data = {exp_q1[0], exp_q0[0]};
    if (fl) begin
      exp_q0.delete();
      exp_q1.delete();
    end else begin
      if (exp_valid) begin
        void'(exp_q0.pop_front());
        void'(exp_q1.pop_front());
      end
      if (wr[0] && (sz[0] < DEPTH || rd)) exp_q0.push_back(d[0]);
      if (wr[1] && (sz[1] < DEPTH || rd)) exp_q1.push_back(d[1]);
    end
    m_state = ns;
    m_lock  = nl;
  endtask

  task automatic step();
    model_step();
    @(posedge fsm_clk);
    #1;
  endtask

  task automatic clear_stim();
    for (int c = 0; c < 64; c++) begin
      sv_v[0][c] = 1'b0;
      sv_v[1][c] = 1'b0;
      sv_d[0][c] = 8'h00;
      sv_d[1][c] = 8'h00;
      sv_en[c]   = 1'b1;
      sv_rl[c]   = 1'b0;
    end
    got.delete();
  endtask

  task automatic put_stream(input int lane, input int start, input int n);
    sv_v[lane][start] = 1'b1;
    sv_d[lane][start] = MARK;
    for (int k = 1; k <= n; k++) begin
      sv_v[lane][start+k] = 1'b1;
      sv_d[lane][start+k] = 8'(k);
    end
  endtask

  task automatic drive_cycle(input int c);
    in_valid = {sv_v[1][c], sv_v[0][c]};
    in_data  = {sv_d[1][c], sv_d[0][c]};
    enable   = sv_en[c];
    realign  = sv_rl[c];
    step();
    if (out_valid) got.push_back(out_data);
  endtask

  task automatic to_search();
    in_valid = 2'b00;
    realign  = 1'b0;
    enable   = 1'b0;
    step();
    enable = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; realign = 1'b0; in_valid = 2'b00; in_data = 16'h0;
    #1 rst = 1'b0;
    #1;
    n_vec++;
    if ({out_valid, aligned, skew_error} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_flags: got v/al/er=%b%b%b exp 000", out_valid, aligned, skew_error);
    end
    n_vec++;
    if (out_data !== 16'h0000) begin
      n_err++;
      $display("FAIL reset_data: got %h exp 0000", out_data);
    end
    n_vec++;
    if (state !== IDLE) begin
      n_err++;
      $display("FAIL reset_state: got %0d exp %0d", state, IDLE);
    end
`ifdef DESKEW_STATS_EN
    n_vec++;
    if (max_skew !== '0) begin
      n_err++;
      $display("FAIL reset_max_skew: got %0d exp 0", max_skew);
    end
`endif
    repeat (2) @(posedge fsm_clk);
    #2 rst = 1'b1;
    model_reset();
    @(posedge fsm_clk);
    #1;
  endtask

  task automatic test_zero_skew();
    to_search();
    clear_stim();
    put_stream(0, 0, 3);
    put_stream(1, 0, 3);
    for (int c = 0; c < 8; c++) begin
      drive_cycle(c);
      n_vec++;
      if ({state, aligned, skew_error, out_valid, out_data} !==
          {m_state, (m_state == ALIGNED), exp_err, exp_valid, exp_data}) begin
        n_err++;
        $display("FAIL zero_skew c%0d: got st=%0d al=%b er=%b v=%b d=%h exp st=%0d er=%b v=%b d=%h",
                 c, state, aligned, skew_error, out_valid, out_data, m_state, exp_err, exp_valid, exp_data);
      end
      if (c == 1) begin
        n_vec++;
        if (aligned !== 1'b1) begin
          n_err++;
          $display("FAIL zero_skew_aligned: got %b exp 1 at cycle 2", aligned);
        end
      end
    end
    n_vec++;
    if (got.size() != 3 || got[0] !== 16'h0101 || got[1] !== 16'h0202 || got[2] !== 16'h0303) begin
      n_err++;
      $display("FAIL zero_skew_words: got %0d words first=%h exp 3 words 0101,0202,0303",
               got.size(), (got.size() > 0) ? got[0] : 16'hxxxx);
    end
  endtask

  task automatic test_skew3();
    int errs;
    to_search();
    clear_stim();
    put_stream(0, 0, 3);
    put_stream(1, 3, 3);
    errs = 0;
    for (int c = 0; c < 12; c++) begin
      drive_cycle(c);
      if (skew_error) errs++;
      n_vec++;
      if ({state, aligned, skew_error, out_valid, out_data} !==
          {m_state, (m_state == ALIGNED), exp_err, exp_valid, exp_data}) begin
        n_err++;
        $display("FAIL skew3 c%0d: got st=%0d er=%b v=%b d=%h exp st=%0d er=%b v=%b d=%h",
                 c, state, skew_error, out_valid, out_data, m_state, exp_err, exp_valid, exp_data);
      end
    end
    n_vec++;
    if (errs != 0 || got.size() != 3 || got[0] !== 16'h0101 || got[1] !== 16'h0202 || got[2] !== 16'h0303) begin
      n_err++;
      $display("FAIL skew3_words: got %0d words, %0d errors; exp 3 words 0101,0202,0303, 0 errors",
               got.size(), errs);
    end
`ifdef DESKEW_STATS_EN
    n_vec++;
    if (max_skew !== CW'(3)) begin
      n_err++;
      $display("FAIL skew3_max_skew: got %0d exp 3", max_skew);
    end
`endif
  endtask

  task automatic test_skew5();
    int errs, al;
    to_search();
    clear_stim();
    put_stream(0, 0, 8);
    put_stream(1, 5, 3);
    errs = 0;
    al   = 0;
    for (int c = 0; c < 13; c++) begin
      drive_cycle(c);
      if (skew_error) errs++;
      if (aligned) al++;
      n_vec++;
      if ({state, aligned, skew_error, out_valid, out_data} !==
          {m_state, (m_state == ALIGNED), exp_err, exp_valid, exp_data}) begin
        n_err++;
        $display("FAIL skew5 c%0d: got st=%0d er=%b v=%b exp st=%0d er=%b v=%b",
                 c, state, skew_error, out_valid, m_state, exp_err, exp_valid);
      end
      if (c == 5) begin
        n_vec++;
        if (skew_error !== 1'b1 || state !== ERROR) begin
          n_err++;
          $display("FAIL skew5_pulse: got er=%b st=%0d exp er=1 st=%0d", skew_error, state, ERROR);
        end
      end
      if (c == 6) begin
        n_vec++;
        if (skew_error !== 1'b0 || state !== SEARCH) begin
          n_err++;
          $display("FAIL skew5_recover: got er=%b st=%0d exp er=0 st=%0d", skew_error, state, SEARCH);
        end
      end
    end
    n_vec++;
    if (errs != 1 || al != 0) begin
      n_err++;
      $display("FAIL skew5_summary: got %0d error pulses, %0d aligned cycles; exp 1 and 0", errs, al);
    end
  endtask

  task automatic test_realign();
    int early;
    to_search();
    clear_stim();
    put_stream(0, 0, 6);
    put_stream(1, 2, 6);
    sv_rl[5] = 1'b1;
    sv_v[0][10] = 1'b1; sv_d[0][10] = MARK;
    sv_v[1][10] = 1'b1; sv_d[1][10] = MARK;
    for (int k = 1; k <= 3; k++) begin
      sv_v[0][10+k] = 1'b1; sv_d[0][10+k] = 8'h09 + 8'(k);
      sv_v[1][10+k] = 1'b1; sv_d[1][10+k] = 8'h09 + 8'(k);
    end
    early = 0;
    for (int c = 0; c < 17; c++) begin
      drive_cycle(c);
      if (c == 5) got.delete();
      if (c >= 5 && c <= 11 && out_valid) early++;
      n_vec++;
      if ({state, aligned, skew_error, out_valid, out_data} !==
          {m_state, (m_state == ALIGNED), exp_err, exp_valid, exp_data}) begin
        n_err++;
        $display("FAIL realign c%0d: got st=%0d v=%b d=%h exp st=%0d v=%b d=%h",
                 c, state, out_valid, out_data, m_state, exp_valid, exp_data);
      end
      if (c == 5) begin
        n_vec++;
        if (aligned !== 1'b0 || state !== SEARCH) begin
          n_err++;
          $display("FAIL realign_drop: got al=%b st=%0d exp al=0 st=%0d", aligned, state, SEARCH);
        end
      end
    end
    n_vec++;
    if (early != 0 || got.size() != 3 || got[0] !== 16'h0A0A || got[1] !== 16'h0B0B || got[2] !== 16'h0C0C) begin
      n_err++;
      $display("FAIL realign_relock: got %0d stale, %0d words first=%h exp 0 stale, 0A0A,0B0B,0C0C",
               early, got.size(), (got.size() > 0) ? got[0] : 16'hxxxx);
    end
  endtask

  task automatic test_enable_drop();
    int al;
    to_search();
    clear_stim();
    sv_v[0][0] = 1'b1; sv_d[0][0] = MARK;
    sv_en[2]   = 1'b0;
    sv_v[1][5] = 1'b1; sv_d[1][5] = MARK;
    for (int c = 6; c < 11; c++) begin
      sv_v[0][c] = 1'b1; sv_d[0][c] = 8'h10 + 8'(c);
      sv_v[1][c] = 1'b1; sv_d[1][c] = 8'h20 + 8'(c);
    end
    al = 0;
    for (int c = 0; c < 16; c++) begin
      drive_cycle(c);
      if (aligned) al++;
      n_vec++;
      if ({state, aligned, skew_error, out_valid, out_data} !==
          {m_state, (m_state == ALIGNED), exp_err, exp_valid, exp_data}) begin
        n_err++;
        $display("FAIL enable_drop c%0d: got st=%0d al=%b v=%b exp st=%0d v=%b",
                 c, state, aligned, out_valid, m_state, exp_valid);
      end
      if (c == 2) begin
        n_vec++;
        if (state !== IDLE) begin
          n_err++;
          $display("FAIL enable_drop_idle: got st=%0d exp %0d", state, IDLE);
        end
      end
    end
    n_vec++;
    if (al != 0) begin
      n_err++;
      $display("FAIL enable_drop_never_aligned: got %0d aligned cycles exp 0", al);
    end
  endtask

  task automatic test_random();
    to_search();
    for (int c = 0; c < 600; c++) begin
      enable  = ($urandom_range(0, 59) != 0);
      realign = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 7) != 0) in_valid = 2'b11;
      else in_valid = 2'($urandom_range(0, 3));
      for (int l = 0; l < 2; l++) begin
        if ($urandom_range(0, 5) == 0) in_data[l*8 +: 8] = MARK;
        else in_data[l*8 +: 8] = 8'($urandom_range(0, 255));
      end
      step();
      n_vec++;
      if ({state, aligned, skew_error, out_valid, out_data} !==
          {m_state, (m_state == ALIGNED), exp_err, exp_valid, exp_data}) begin
        n_err++;
        $display("FAIL random c%0d: got st=%0d er=%b v=%b d=%h exp st=%0d er=%b v=%b d=%h",
                 c, state, skew_error, out_valid, out_data, m_state, exp_err, exp_valid, exp_data);
      end
`ifdef DESKEW_STATS_EN
      n_vec++;
      if (max_skew !== CW'(m_max)) begin
        n_err++;
        $display("FAIL random_max_skew c%0d: got %0d exp %0d", c, max_skew, m_max);
      end
`endif
    end
    realign = 1'b0;
    enable  = 1'b1;
  endtask

  task automatic test_reset_midstream();
    to_search();
    clear_stim();
    put_stream(0, 0, 6);
    put_stream(1, 0, 6);
    for (int c = 0; c < 4; c++) drive_cycle(c);
    n_vec++;
    if (state !== ALIGNED) begin
      n_err++;
      $display("FAIL midreset_pre: got st=%0d exp %0d", state, ALIGNED);
    end
    #2 rst = 1'b0;
    #1;
    n_vec++;
    if ({out_valid, aligned, skew_error} !== 3'b000 || state !== IDLE || out_data !== 16'h0) begin
      n_err++;
      $display("FAIL midreset_outputs: got v/al/er=%b%b%b st=%0d d=%h exp 000 st=0 d=0000",
               out_valid, aligned, skew_error, state, out_data);
    end
    in_valid = 2'b00;
    enable   = 1'b1;
    @(posedge fsm_clk);
    @(posedge fsm_clk);
    #2 rst = 1'b1;
    model_reset();
    @(posedge fsm_clk);
    #1;
    clear_stim();
    sv_v[0][1] = 1'b1; sv_d[0][1] = MARK;
    sv_v[1][1] = 1'b1; sv_d[1][1] = MARK;
    for (int k = 2; k <= 4; k++) begin
      sv_v[0][k] = 1'b1; sv_d[0][k] = 8'h53 + 8'(k);
      sv_v[1][k] = 1'b1; sv_d[1][k] = 8'h53 + 8'(k);
    end
    for (int c = 0; c < 9; c++) begin
      drive_cycle(c);
      n_vec++;
      if ({state, aligned, skew_error, out_valid, out_data} !==
          {m_state, (m_state == ALIGNED), exp_err, exp_valid, exp_data}) begin
        n_err++;
        $display("FAIL midreset_relock c%0d: got st=%0d v=%b d=%h exp st=%0d v=%b d=%h",
                 c, state, out_valid, out_data, m_state, exp_valid, exp_data);
      end
    end
    n_vec++;
    if (got.size() != 3 || got[0] !== 16'h5555) begin
      n_err++;
      $display("FAIL midreset_counts: got %0d words first=%h exp 3 words first=5555",
               got.size(), (got.size() > 0) ? got[0] : 16'hxxxx);
    end
  endtask

  initial begin
    test_reset();
    test_zero_skew();
    test_skew3();
    test_skew5();
    test_realign();
    test_enable_drop();
    test_random();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
